score_uart_tx: RTL
==================

Name: score_uart_tx

Overview:
Consumer end of the day-3 accumulator. It takes the final 32-bit score and converts it to unsigned decimal ASCII with a sequential double-dabble. It then serialises the characters out of a UART 8N1 transmitter, so the FPGA reports its answer on a serial pin. It sits downstream of the score accumulator, and `start` is driven when the accumulator finishes.

Parameters:
- CLKS_PER_BIT, 4, clk cycles per UART bit period; legal minimum 2.
- VALUE_W, 32, width of the input score; the design is fixed at 32, giving 10 decimal digits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  single-cycle request to transmit `value`
- value  in  32  unsigned score, sampled in the cycle `start` is accepted
- busy  out  1  high from the cycle after acceptance until transmission completes
- done  out  1  one-cycle pulse when the last stop bit ends
- tx  out  1  UART line; idles high

Behaviour:
- Reset values: tx=1, busy=0, done=0, FSM=IDLE, all internal registers 0. Reset applies on the next edge from any state.
- Reset mid-character: tx returns to 1 on the following cycle and no partial stop bit is emitted.
- States: IDLE -> CONVERT -> SEND -> IDLE.
- IDLE:
  - `start`=1 latches `value` into a shift register, clears the 40-bit BCD register and goes to CONVERT.
  - busy=1 from the next cycle.
- CONVERT:
  - Exactly 32 cycles, one double-dabble iteration per cycle.
  - Each iteration: add 3 to every BCD nibble that is >=5, then shift {bcd,bin} left by 1.
  - After the 32nd iteration, go to SEND with the digit index at the most significant digit (9).
- Leading-zero suppression:
  - Digits above the most significant nonzero digit are skipped with no cycle cost.
  - Digit 0 (least significant) is always sent, so value 0 gives "0".
- SEND:
  - Each character byte is 0x30+digit.
  - Byte framing: start bit 0, data bits LSB first, stop bit 1. Each bit holds for CLKS_PER_BIT cycles, so one frame is 10*CLKS_PER_BIT cycles.
  - Characters are sent back-to-back with no idle gap between frames.
- Total transmit time: N characters = N*10*CLKS_PER_BIT cycles. The first start bit drives tx low in the first cycle of SEND.
- Completion:
  - After the last frame's stop period: busy=0 and done=1 for one cycle, FSM=IDLE.
  - `start` in the done cycle is accepted.
- `start` while busy=1 is ignored; `value` changes while busy have no effect.
- Arithmetic:
  - Nibble add-3 is 4-bit with no overflow, since the input is <=9 before the shift.
  - The BCD register is 40 bits; 0xFFFFFFFF gives "4294967295".
- Bit-period counter: width $clog2(CLKS_PER_BIT), wraps to 0 at CLKS_PER_BIT-1. The bit index counts 0..9 per frame.

Optional Feature:
- SCORE_TX_NEWLINE_EN defined: after the last digit, frames CR (0x0D) then LF (0x0A) are sent back-to-back before done. Total = (N+2)*10*CLKS_PER_BIT cycles.
- Undefined: only digits are sent, and done follows the last digit's stop bit.

Decomposition:
- Package aoc_tx_pkg:
  - constants ASCII_ZERO=8'h30, ASCII_CR=8'h0D, ASCII_LF=8'h0A, NUM_DIGITS=10, BCD_W=40
  - FSM state encoding IDLE/CONVERT/SEND
- Sub-module uart_tx_byte (CLKS_PER_BIT parameter):
  - inputs: byte valid/data
  - outputs: ready, tx
  - accepts a new byte in the cycle its previous stop bit ends, so there is zero gap.
- The top holds the FSM, double-dabble and digit sequencer.

Test Plan:
1. Reset with CLKS_PER_BIT=4 -> tx=1, busy=0, done=0. Hold rst during a frame -> tx=1 the cycle after.
2. value=357, start -> busy next cycle; tx low 32 cycles after acceptance. Bytes 0x33,0x35,0x37 decoded with no gap, then done after 120 tx cycles (with SCORE_TX_NEWLINE_EN: +0x0D,0x0A, 200 cycles).
3. value=0 -> single byte 0x30, 40 tx cycles, done pulse exactly 1 cycle.
4. value=0xFFFFFFFF -> "4294967295", 10 bytes, 400 tx cycles; value=1000000000 -> "1000000000", zeros inside the number kept.
5. start pulsed again mid-SEND with a different value -> ignored, output unchanged. start in the done cycle -> accepted, busy=1 the next cycle.
6. CLKS_PER_BIT=2, value=9 -> byte 0x39, each bit held exactly 2 cycles, frame 20 cycles.

Source files
------------

// File: rtl/aoc_tx_pkg.sv
// rtl/aoc_tx_pkg.sv - shared constants and BCD helpers for the score UART transmitter
package aoc_tx_pkg;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam int         NUM_DIGITS = 10;
    localparam int         BCD_W      = 40;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_SEND    = 2'd2;

    // Double-dabble correction: any digit >= 5 would exceed 9 after the
    // following shift, so bias it by 3 to carry correctly into the next digit.
    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Index of the most significant nonzero digit; 0 when the value is zero,
    // so the least significant digit is always sent.
    function automatic logic [3:0] msd_index(input logic [BCD_W-1:0] bcd);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] bcd, input logic [3:0] idx);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == 4'(i)) begin
                d = bcd[4*i +: 4];
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 UART byte serialiser with zero-gap back-to-back framing
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   byte_valid_i    a byte is offered on byte_data_i
//   byte_data_i     byte to frame, sent LSB first
//   ready_o         byte is taken this cycle if byte_valid_i is high
//   tx_o            registered serial line, idles high
//
// A byte is accepted one cycle before its start bit appears on tx_o. While a
// frame is active, ready_o rises only in the final cycle of the stop bit, so a
// byte offered then starts its start bit immediately after the stop bit.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_data_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             active_q, active_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [3:0]       bit_q,    bit_d;     // 0 start, 1..8 data, 9 stop
    logic [7:0]       shift_q,  shift_d;
    logic             tx_q,     tx_d;

    logic bit_end;
    logic frame_end;
    logic load;

    assign bit_end   = (cnt_q == CNT_LAST);
    assign frame_end = active_q && bit_end && (bit_q == 4'd9);
    assign ready_o   = !active_q || frame_end;
    assign load      = byte_valid_i && ready_o;
    assign tx_o      = tx_q;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        if (load) begin
            active_d = 1'b1;
            cnt_d    = '0;
            bit_d    = 4'd0;
            shift_d  = byte_data_i;
            tx_d     = 1'b0;
        end else if (frame_end) begin
            active_d = 1'b0;
            cnt_d    = '0;
            bit_d    = 4'd0;
            tx_d     = 1'b1;
        end else if (active_q) begin
            if (bit_end) begin
                cnt_d = '0;
                bit_d = bit_q + 4'd1;
                if (bit_q < 4'd8) begin
                    tx_d    = shift_q[0];
                    shift_d = {1'b0, shift_q[7:1]};
                end else begin
                    tx_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= 4'd0;
            shift_q  <= 8'd0;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: rtl/score_uart_tx.sv
// rtl/score_uart_tx.sv - 32-bit score to decimal ASCII over UART 8N1
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      single-cycle request to send value (ignored while busy)
//   value      unsigned score, sampled when start is accepted
//   busy       high from the cycle after acceptance until transmission ends
//   done       one-cycle pulse after the last stop bit
//   tx         UART line, idles high
//
// Optional build macro: SCORE_TX_NEWLINE_EN appends CR, LF after the digits.
//
// Flow: IDLE -> CONVERT (32 double-dabble iterations) -> SEND -> IDLE.
// The first character is handed to the UART during the last CONVERT cycle,
// using the BCD result being produced that cycle, so its start bit lands in
// the first SEND cycle.
module score_uart_tx
    import aoc_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int VALUE_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [VALUE_W-1:0] value,
    output logic               busy,
    output logic               done,
    output logic               tx
);

    logic [1:0]         state_q, state_d;
    logic [VALUE_W-1:0] bin_q,   bin_d;
    logic [BCD_W-1:0]   bcd_q,   bcd_d;
    logic [4:0]         iter_q,  iter_d;
    logic [3:0]         dig_q,   dig_d;    // digit index of the frame in flight
    logic               done_q,  done_d;
`ifdef SCORE_TX_NEWLINE_EN
    logic [1:0]         nl_q,    nl_d;     // 0 digits, 1 CR in flight, 2 LF in flight
`endif

    logic [BCD_W+VALUE_W-1:0] dd_shift;
    logic [BCD_W-1:0]         bcd_next;
    logic [VALUE_W-1:0]       bin_next;
    logic [3:0]               first_dig;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       tx_ready;

    assign dd_shift  = {bcd_adjust(bcd_q), bin_q} << 1;
    assign bcd_next  = dd_shift[BCD_W+VALUE_W-1 -: BCD_W];
    assign bin_next  = dd_shift[VALUE_W-1:0];
    assign first_dig = msd_index(bcd_next);

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        iter_d     = iter_q;
        dig_d      = dig_q;
        done_d     = 1'b0;
`ifdef SCORE_TX_NEWLINE_EN
        nl_d       = nl_q;
`endif
        byte_valid = 1'b0;
        byte_data  = ASCII_ZERO;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_d   = value;
                    bcd_d   = '0;
                    iter_d  = 5'd0;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                bin_d  = bin_next;
                bcd_d  = bcd_next;
                iter_d = iter_q + 5'd1;
                if (iter_q == 5'd31) begin
                    byte_valid = 1'b1;
                    byte_data  = ASCII_ZERO + {4'd0, digit_at(bcd_next, first_dig)};
                    dig_d      = first_dig;
`ifdef SCORE_TX_NEWLINE_EN
                    nl_d       = 2'd0;
`endif
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                // In SEND the UART is always mid-frame, so ready means the
                // current stop bit is in its final cycle.
                if (tx_ready) begin
                    if (dig_q != 4'd0
`ifdef SCORE_TX_NEWLINE_EN
                        && nl_q == 2'd0
`endif
                    ) begin
                        byte_valid = 1'b1;
                        byte_data  = ASCII_ZERO + {4'd0, digit_at(bcd_q, dig_q - 4'd1)};
                        dig_d      = dig_q - 4'd1;
                    end
`ifdef SCORE_TX_NEWLINE_EN
                    else if (nl_q == 2'd0) begin
                        byte_valid = 1'b1;
                        byte_data  = ASCII_CR;
                        nl_d       = 2'd1;
                    end else if (nl_q == 2'd1) begin
                        byte_valid = 1'b1;
                        byte_data  = ASCII_LF;
                        nl_d       = 2'd2;
                    end
`endif
                    else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            iter_q  <= 5'd0;
            dig_q   <= 4'd0;
            done_q  <= 1'b0;
`ifdef SCORE_TX_NEWLINE_EN
            nl_q    <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            dig_q   <= dig_d;
            done_q  <= done_d;
`ifdef SCORE_TX_NEWLINE_EN
            nl_q    <= nl_d;
`endif
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk         (clk),
        .rst         (rst),
        .byte_valid_i(byte_valid),
        .byte_data_i (byte_data),
        .ready_o     (tx_ready),
        .tx_o        (tx)
    );

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule
